// File: rtl/axi_write_responder_pkg.sv
// Shared types for the AXI write responder: burst/response encodings, FSM states and the queued AW entry.
// Queue entries are sized by the package widths below; the top's width parameters default to them.
package axi_write_responder_pkg;

  localparam int AW_ID_W   = 4;
  localparam int AW_ADDR_W = 32;
  localparam int AW_LEN_W  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AW_ID_W-1:0]   id;
    logic [AW_ADDR_W-1:0] addr;
    logic [AW_LEN_W-1:0]  len;
    logic [2:0]           size;
    burst_e               burst;
  } aw_req_t;

  // WRAP is not supported here, and beats wider than the data bus cannot be honoured.
  function automatic logic burst_illegal(burst_e burst, logic [2:0] size, logic [2:0] max_size);
    return (burst == BURST_WRAP) || (burst == BURST_RSVD) || (size > max_size);
  endfunction

endpackage

// File: rtl/axi_write_responder_if.sv
// AW/W/B channel bundle between a write master and the responder; master drives AW, W and bready.
interface axi_write_responder_if #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int DATA_BYTES = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_W-1:0]         awid;
  logic [ADDR_W-1:0]       awaddr;
  logic [LEN_W-1:0]        awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [ID_W-1:0]         wid;
  logic [8*DATA_BYTES-1:0] wdata;
  logic [DATA_BYTES-1:0]   wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [ID_W-1:0]         bid;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_aw_queue.sv
// Synchronous FIFO of AW requests; head visible combinationally, push/pop take effect at the clock edge.
// Backpressure: full is from the registered count only, so a same-cycle pop never frees a slot for a push.
module axi_aw_queue
  import axi_write_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  aw_req_t push_data,
  input  logic    pop,
  output aw_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  aw_req_t          slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_write_responder.sv
// AXI3 write slave endpoint: each accepted beat reaches the memory port one cycle after its W handshake; one B per burst.
// AW stalls only while the queue is full; W is accepted only mid-burst; B is held stable until bready.
module axi_write_responder
  import axi_write_responder_pkg::*;
#(
  parameter int ID_W       = AW_ID_W,
  parameter int ADDR_W     = AW_ADDR_W,
  parameter int LEN_W      = AW_LEN_W,
  parameter int DATA_BYTES = 4,
  parameter int AW_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_write_responder_if.slave    bus,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic [DATA_BYTES-1:0]   mem_wstrb
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

  state_e            state;
  aw_req_t           push_req;
  aw_req_t           head;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;

  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cur_len;
  logic [2:0]        cur_size;
  burst_e            cur_burst;
  logic [LEN_W:0]    beat_cnt;
  logic              err;

  logic [LEN_W:0]    len_ext;
  logic              w_hs;
  logic              at_last;
  logic              beat_ok;
  logic              err_next;

  assign bus.awready = !q_full && !rst;
  assign q_push      = bus.awvalid && bus.awready;
  assign q_pop       = (state == ST_IDLE) && !q_empty;
  assign push_req    = '{id:    bus.awid,
                         addr:  bus.awaddr,
                         len:   bus.awlen,
                         size:  bus.awsize,
                         burst: burst_e'(bus.awburst)};

  axi_aw_queue #(
    .DEPTH(AW_DEPTH)
  ) u_aw_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (push_req),
    .pop       (q_pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // beat_cnt saturates at len+1, so any beat past the last one fails the range test.
  assign len_ext  = {1'b0, cur_len};
  assign w_hs     = bus.wvalid && bus.wready;
  assign at_last  = (beat_cnt == len_ext);
  assign beat_ok  = !err && (bus.wid == cur_id) && (beat_cnt <= len_ext);
  assign err_next = !beat_ok || (bus.wlast != at_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bus.wready <= 1'b0;
      bus.bvalid <= 1'b0;
      bus.bid    <= '0;
      bus.bresp  <= RESP_OKAY;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      cur_id     <= '0;
      cur_addr   <= '0;
      cur_len    <= '0;
      cur_size   <= '0;
      cur_burst  <= BURST_FIXED;
      beat_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            cur_id     <= head.id;
            cur_addr   <= head.addr;
            cur_len    <= head.len;
            cur_size   <= head.size;
            cur_burst  <= head.burst;
            beat_cnt   <= '0;
            err        <= burst_illegal(head.burst, head.size, MAX_SIZE);
            bus.wready <= 1'b1;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_hs) begin
            if (beat_ok) begin
              mem_we    <= 1'b1;
              mem_addr  <= cur_addr;
              mem_wdata <= bus.wdata;
              mem_wstrb <= bus.wstrb;
            end
            if (cur_burst == BURST_INCR) begin
              cur_addr <= cur_addr + (ADDR_W'(1) << cur_size);
            end
            if (beat_cnt <= len_ext) begin
              beat_cnt <= beat_cnt + (LEN_W+1)'(1);
            end
            err <= err_next;
            if (bus.wlast) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bid    <= cur_id;
              bus.bresp  <= err_next ? RESP_SLVERR : RESP_OKAY;
              state      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bus.bready) begin
            bus.bvalid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed and randomized bursts for axi_write_responder, checked against a burst-level model of expected writes and B responses.
module tb_axi_write_responder;

  localparam int ID_W       = 4;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 8;
  localparam int DATA_BYTES = 4;
  localparam int AW_DEPTH   = 4;
  localparam int NSLOT      = 8;
  localparam int NBEAT      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi_write_responder_if #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_BYTES(DATA_BYTES)
  ) bus ();

  axi_write_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_BYTES(DATA_BYTES), .AW_DEPTH(AW_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  int  total = 0;
  int  bad   = 0;

  logic [3:0]  p_id    [NSLOT];
  logic [31:0] p_addr  [NSLOT];
  logic [7:0]  p_len   [NSLOT];
  logic [2:0]  p_size  [NSLOT];
  logic [1:0]  p_burst [NSLOT];
  int          p_n     [NSLOT];
  bit          p_aband [NSLOT];
  logic [3:0]  p_wid   [NSLOT][NBEAT];
  logic [31:0] p_data  [NSLOT][NBEAT];
  logic [3:0]  p_strb  [NSLOT][NBEAT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a beat lands in memory only if the burst is legal so far, its wid matches and it is within len.
  task automatic plan_burst(input int s, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int n, input int bad_beat,
                            input bit abandon);
    bit  err;
    bit  last;
    wr_t w;
    b_t  b;
    p_id[s] = id; p_addr[s] = addr; p_len[s] = len; p_size[s] = size; p_burst[s] = burst;
    p_n[s] = n; p_aband[s] = abandon;
    err = (burst >= 2'd2) || (int'(size) > $clog2(DATA_BYTES));
    for (int k = 0; k < n; k++) begin
      p_wid[s][k]  = (k == bad_beat) ? id + 4'd1 : id;
      p_data[s][k] = $urandom;
      p_strb[s][k] = 4'($urandom);
      last = !abandon && (k == n - 1);
      if (!err && p_wid[s][k] == id && k <= int'(len)) begin
        w.addr = (burst == 2'b00) ? addr : addr + 32'(k) * (32'd1 << size);
        w.data = p_data[s][k];
        w.strb = p_strb[s][k];
        exp_wr.push_back(w);
      end else begin
        err = 1'b1;
      end
      if (last != (k == int'(len))) err = 1'b1;
    end
    if (!abandon) begin
      b.id   = id;
      b.resp = err ? 2'b10 : 2'b00;
      exp_b.push_back(b);
    end
  endtask

  task automatic send_aw(input int s);
    bit hs = 1'b0;
    bus.awvalid = 1'b1;
    bus.awid    = p_id[s];
    bus.awaddr  = p_addr[s];
    bus.awlen   = p_len[s];
    bus.awsize  = p_size[s];
    bus.awburst = p_burst[s];
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = (bus.awready === 1'b1);
      @(posedge clk);
      #1;
    end
    bus.awvalid = 1'b0;
    chk("aw_accept", 64'(hs), 64'(1));
  endtask

  task automatic send_w(input int s);
    bit hs;
    for (int k = 0; k < p_n[s]; k++) begin
      hs = 1'b0;
      bus.wvalid = 1'b1;
      bus.wid    = p_wid[s][k];
      bus.wdata  = p_data[s][k];
      bus.wstrb  = p_strb[s][k];
      bus.wlast  = !p_aband[s] && (k == p_n[s] - 1);
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge clk);
        hs = (bus.wready === 1'b1);
        @(posedge clk);
        #1;
      end
      chk("w_accept", 64'(hs), 64'(1));
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    if (!p_aband[s]) chk("bvalid_after_wlast", 64'(bus.bvalid), 64'(1));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk);
      #1;
      done = (exp_wr.size() == 0) && (exp_b.size() == 0);
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  task automatic run_one(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int n, input int bad_beat);
    plan_burst(0, id, addr, len, size, burst, n, bad_beat, 1'b0);
    send_aw(0);
    send_w(0);
    drain();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awready"}, 64'(bus.awready), 64'(0));
    chk({tag, "_wready"},  64'(bus.wready),  64'(0));
    chk({tag, "_bvalid"},  64'(bus.bvalid),  64'(0));
    chk({tag, "_bid"},     64'(bus.bid),     64'(0));
    chk({tag, "_bresp"},   64'(bus.bresp),   64'(0));
    chk({tag, "_mem_we"},  64'(mem_we),      64'(0));
    chk({tag, "_maddr"},   64'(mem_addr),    64'(0));
    chk({tag, "_mdata"},   64'(mem_wdata),   64'(0));
    chk({tag, "_mstrb"},   64'(mem_wstrb),   64'(0));
  endtask

  always @(negedge clk) begin
    wr_t w;
    b_t  b;
    if (mem_we === 1'b1) begin
      chk("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(mem_addr),  64'(w.addr));
        chk("wr_data", 64'(mem_wdata), 64'(w.data));
        chk("wr_strb", 64'(mem_wstrb), 64'(w.strb));
      end
    end
    if (bus.bvalid === 1'b1 && bus.bready === 1'b1) begin
      chk("b_expected", 64'(exp_b.size() != 0), 64'(1));
      if (exp_b.size() != 0) begin
        b = exp_b.pop_front();
        chk("b_id",   64'(bus.bid),   64'(b.id));
        chk("b_resp", 64'(bus.bresp), 64'(b.resp));
      end
    end
  end

  initial begin
    int          mode;
    int          n;
    int          bb;
    int          r;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;

    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid  = 1'b0; bus.wid  = '0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast  = 1'b0;
    bus.bready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    #1;
    chk("awready_out_of_reset", 64'(bus.awready), 64'(1));
    @(posedge clk);
    #1;

    // INCR 4 beats at 0x100, then FIXED 2 beats at 0x40
    run_one(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, 4, -1);
    run_one(4'h7, 32'h40,  8'd1, 3'd2, 2'b00, 2, -1);
    // Early wlast on beat 1 of 4, then a normal burst
    run_one(4'h2, 32'h100, 8'd3, 3'd2, 2'b01, 2, -1);
    run_one(4'h4, 32'h180, 8'd2, 3'd1, 2'b01, 3, -1);
    // Wrong wid on beat 1, WRAP, oversize beat, missing wlast at beat len
    run_one(4'h5, 32'h300, 8'd3, 3'd2, 2'b01, 4, 1);
    run_one(4'h9, 32'h400, 8'd3, 3'd2, 2'b10, 4, -1);
    run_one(4'hA, 32'h500, 8'd1, 3'd3, 2'b01, 2, -1);
    run_one(4'hB, 32'h600, 8'd1, 3'd2, 2'b01, 4, -1);
    // Address wraps at the top of the address space
    run_one(4'hE, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 2, -1);

    // Queue fill with B held off
    bus.bready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      plan_burst(s, 4'(s + 1), 32'h1000 + 32'(s * 16), 8'd1, 3'd2, 2'b01, 2, -1, 1'b0);
    end
    for (int s = 0; s < 5; s++) send_aw(s);
    chk("awready_full", 64'(bus.awready), 64'(0));
    send_w(0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("b_hold_valid", 64'(bus.bvalid), 64'(1));
      chk("b_hold_id",    64'(bus.bid),    64'(p_id[0]));
      chk("b_hold_full",  64'(bus.awready), 64'(0));
    end
    bus.bready = 1'b1;
    for (int s = 1; s < 5; s++) send_w(s);
    drain();

    // Reset in the middle of a 4-beat burst after two beats
    plan_burst(0, 4'hC, 32'h200, 8'd3, 3'd2, 2'b01, 2, -1, 1'b1);
    send_aw(0);
    send_w(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("midrst");
    chk("midrst_writes_seen", 64'(exp_wr.size()), 64'(0));
    rst = 1'b0;
    #1;
    chk("midrst_awready", 64'(bus.awready), 64'(1));
    @(posedge clk);
    #1;
    chk("midrst_idle_wready", 64'(bus.wready), 64'(0));
    chk("midrst_no_b",        64'(bus.bvalid), 64'(0));
    run_one(4'hD, 32'h800, 8'd3, 3'd2, 2'b01, 4, -1);

    // Randomized bursts, including illegal ones
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 9));
      len  = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      r    = int'($urandom_range(0, 9));
      burst = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      n    = int'(len) + 1;
      bb   = -1;
      if (mode == 7) bb = int'($urandom_range(0, int'(len)));
      if (mode == 8 && len != 0) n = int'($urandom_range(1, int'(len)));
      if (mode == 9) n = int'(len) + 2 + int'($urandom_range(0, 1));
      run_one(4'($urandom), $urandom, len, size, burst, n, bb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
